// File: rtl/watch_timekeeper.sv
`timescale 1ns/1ps
// watch_timekeeper: brings the 1 kHz divided clock and the increment button
// into the CLOCK domain and keeps 24-hour BCD time with a set mode and a
// blink strobe for the field being edited.
module watch_timekeeper #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BLINK_HALF    = 500
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       clk_1k,
  input  logic [1:0] set_mode,
  input  logic       inc_btn,
  output logic [1:0] hour_t,
  output logic [3:0] hour_u,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       sec_pulse,
  output logic       blink
);

  localparam logic [15:0] TICK_LAST  = 16'(TICKS_PER_SEC - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);
  localparam logic [1:0]  MODE_RUN   = 2'd0;
  localparam logic [1:0]  MODE_HOUR  = 2'd1;

  logic        s1, s2, s3;
  logic        b1, b2, b3;
  logic        tick, inc_edge;
  logic [1:0]  mode_map, mode_reg;
  logic        mode_chg;
  logic [15:0] tick_cnt, blink_cnt;
  logic        blink_q;
  logic [3:0]  min_u_nx, hour_u_nx;
  logic [2:0]  min_t_nx;
  logic [1:0]  hour_t_nx;
  logic        min_wrap;

  assign tick     = s2 & ~s3;
  assign inc_edge = b2 & ~b3;
  assign mode_map = (set_mode == 2'd3) ? MODE_RUN : set_mode;
  assign mode_chg = (mode_map != mode_reg);
  assign blink    = blink_q & (mode_reg != MODE_RUN);

  // Synchronisers with history flops for edge detection, plus latched mode
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      b1 <= 1'b0; b2 <= 1'b0; b3 <= 1'b0;
      mode_reg <= MODE_RUN;
    end else begin
      s1 <= clk_1k; s2 <= s1; s3 <= s2;
      b1 <= inc_btn; b2 <= b1; b3 <= b2;
      mode_reg <= mode_map;
    end
  end

  // Next-value of the minute and hour fields, shared by carry and set paths
  always_comb begin
    min_wrap  = (min_t == 3'd5) && (min_u == 4'd9);
    min_u_nx  = (min_u == 4'd9) ? 4'd0 : min_u + 4'd1;
    min_t_nx  = min_t;
    if (min_u == 4'd9) min_t_nx = (min_t == 3'd5) ? 3'd0 : min_t + 3'd1;
    hour_u_nx = hour_u + 4'd1;
    hour_t_nx = hour_t;
    if (hour_t == 2'd2 && hour_u == 4'd3) begin
      hour_u_nx = 4'd0;
      hour_t_nx = 2'd0;
    end else if (hour_u == 4'd9) begin
      hour_u_nx = 4'd0;
      hour_t_nx = hour_t + 2'd1;
    end
  end

  // Timekeeping: a mode change wins the cycle, then run ticks or set presses
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hour_t <= 2'd0; hour_u <= 4'd0;
      min_t <= 3'd0; min_u <= 4'd0;
      sec_t <= 3'd0; sec_u <= 4'd0;
      tick_cnt <= 16'd0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      if (mode_chg) begin
        // only entering edit from run restarts the second
        if (mode_reg == MODE_RUN) begin
          sec_t <= 3'd0; sec_u <= 4'd0;
          tick_cnt <= 16'd0;
        end
      end else if (mode_reg == MODE_RUN) begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt  <= 16'd0;
            sec_pulse <= 1'b1;
            if (sec_u != 4'd9) begin
              sec_u <= sec_u + 4'd1;
            end else begin
              sec_u <= 4'd0;
              if (sec_t != 3'd5) begin
                sec_t <= sec_t + 3'd1;
              end else begin
                sec_t <= 3'd0;
                min_u <= min_u_nx; min_t <= min_t_nx;
                if (min_wrap) begin
                  hour_u <= hour_u_nx; hour_t <= hour_t_nx;
                end
              end
            end
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end
      end else if (inc_edge) begin
        if (mode_reg == MODE_HOUR) begin
          hour_u <= hour_u_nx; hour_t <= hour_t_nx;
        end else begin
          min_u <= min_u_nx; min_t <= min_t_nx;
        end
      end
    end
  end

  // Blink half-period counter runs on every tick regardless of mode
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      blink_cnt <= 16'd0;
      blink_q   <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= 16'd0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

endmodule
